// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue path: alu_op encodings, instruction
// opcodes and R-type funct codes, plus the decode result payload.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned OPC_W    = 6;
  localparam int unsigned FUNCT_W  = 6;

  // ALU control encodings
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOR  = 4'b1100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NULL = 4'b1000;

  // Instruction opcodes
  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OPC_SLTI  = 6'h0A;
  localparam logic [OPC_W-1:0] OPC_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OPC_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OPC_XORI  = 6'h0E;

  // R-type funct codes
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR = 6'h26;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'h27;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

  // Decoder result
  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic                illegal;
  } decode_t;

  // Overflow is only meaningful for the arithmetic ops
  function automatic logic ovf_qualified(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decoder: opcode/funct -> alu_op + illegal flag.
// Ports:
//   opcode     : instruction opcode
//   funct      : R-type funct field (only looked at when opcode is R-type)
//   alu_op_c   : ALU control encoding (NULL for unsupported instructions)
//   illegal_c  : set for any unsupported opcode/funct
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [OPC_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALU_OP_W-1:0] alu_op_c,
  output logic                illegal_c
);

  decode_t dec;

  // Unsupported encodings fall through to NULL/illegal via the defaults
  always_comb begin
    dec.op      = ALU_OP_NULL;
    dec.illegal = 1'b1;
    if (opcode == OPC_RTYPE) begin
      case (funct)
        FUNCT_AND: dec = '{op: ALU_OP_AND, illegal: 1'b0};
        FUNCT_OR:  dec = '{op: ALU_OP_OR,  illegal: 1'b0};
        FUNCT_ADD: dec = '{op: ALU_OP_ADD, illegal: 1'b0};
        FUNCT_XOR: dec = '{op: ALU_OP_XOR, illegal: 1'b0};
        FUNCT_SUB: dec = '{op: ALU_OP_SUB, illegal: 1'b0};
        FUNCT_SLT: dec = '{op: ALU_OP_SLT, illegal: 1'b0};
        FUNCT_NOR: dec = '{op: ALU_OP_NOR, illegal: 1'b0};
        default:   dec = '{op: ALU_OP_NULL, illegal: 1'b1};
      endcase
    end else begin
      case (opcode)
        OPC_ADDI: dec = '{op: ALU_OP_ADD, illegal: 1'b0};
        OPC_ANDI: dec = '{op: ALU_OP_AND, illegal: 1'b0};
        OPC_ORI:  dec = '{op: ALU_OP_OR,  illegal: 1'b0};
        OPC_XORI: dec = '{op: ALU_OP_XOR, illegal: 1'b0};
        OPC_SLTI: dec = '{op: ALU_OP_SLT, illegal: 1'b0};
        // BEQ compares by subtraction
        OPC_BEQ:  dec = '{op: ALU_OP_SUB, illegal: 1'b0};
        default:  dec = '{op: ALU_OP_NULL, illegal: 1'b1};
      endcase
    end
  end

  assign alu_op_c  = dec.op;
  assign illegal_c = dec.illegal;

endmodule

// File: rtl/alu_issue_unit.sv
// Two-stage issue unit in front of an external combinational ALU.
// Stage 1 registers the decoded op and operands that drive the ALU; stage 2
// captures the ALU result/flags into an output register with its own
// valid/ready handshake. Saturating counters track delivered responses.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   in_valid/in_ready           : request handshake
//   in_opcode/in_funct/in_a/in_b: instruction fields and operands
//   alu_op_o/alu_a_o/alu_b_o    : registered drives to the ALU
//   alu_result_i/alu_zero_i/alu_ovf_i : ALU outputs
//   out_valid/out_ready         : response handshake
//   out_result/out_zero/out_overflow/out_illegal : response payload
//   cnt_ops/cnt_ovf             : saturating delivered / overflow counts
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ALU_OP_WIDTH = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPC_W-1:0]        in_opcode,
  input  logic [FUNCT_W-1:0]      in_funct,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic [DATA_WIDTH-1:0]   alu_a_o,
  output logic [DATA_WIDTH-1:0]   alu_b_o,
  input  logic [DATA_WIDTH-1:0]   alu_result_i,
  input  logic                    alu_zero_i,
  input  logic                    alu_ovf_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic                    out_zero,
  output logic                    out_overflow,
  output logic                    out_illegal,
  output logic [CNT_WIDTH-1:0]    cnt_ops,
  output logic [CNT_WIDTH-1:0]    cnt_ovf
);

  logic                s1_valid;
  logic                s1_illegal;
  logic [ALU_OP_W-1:0] dec_op;
  logic                dec_illegal;
  logic                advance;
  logic                accept;
  logic                deliver;
  logic                ovf_masked;

  alu_op_decode u_decode (
    .opcode    (in_opcode),
    .funct     (in_funct),
    .alu_op_c  (dec_op),
    .illegal_c (dec_illegal)
  );

  // Handshake: in_ready depends only on registered state and out_ready
  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  // Raw ALU overflow is only passed on for ADD/SUB
  assign ovf_masked = alu_ovf_i && ovf_qualified(ALU_OP_W'(alu_op_o));

  // Stage 1: issue registers feeding the ALU; hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_illegal <= 1'b0;
      alu_op_o   <= '0;
      alu_a_o    <= '0;
      alu_b_o    <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_illegal <= dec_illegal;
      alu_op_o   <= ALU_OP_WIDTH'(dec_op);
      alu_a_o    <= in_a;
      alu_b_o    <= in_b;
    end else if (advance) begin
      s1_valid   <= 1'b0;
    end
  end

  // Stage 2: output register; refills in the same cycle it drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result   <= alu_result_i;
        out_zero     <= alu_zero_i;
        out_overflow <= ovf_masked;
        out_illegal  <= s1_illegal;
      end
    end
  end

  // Saturating statistics on delivered responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ops <= '0;
      cnt_ovf <= '0;
    end else if (deliver) begin
      if (cnt_ops != {CNT_WIDTH{1'b1}}) begin
        cnt_ops <= cnt_ops + CNT_WIDTH'(1);
      end
      if (out_overflow && (cnt_ovf != {CNT_WIDTH{1'b1}})) begin
        cnt_ovf <= cnt_ovf + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with a behavioural ALU attached.
module tb_alu_issue_unit;

  localparam int unsigned DW  = 32;
  localparam int unsigned OW  = 4;
  localparam int unsigned CW  = 4;
  localparam int          SAT = 15;
  localparam longint MAX32 = 64'sd2147483647;
  localparam longint MIN32 = -64'sd2147483648;

  localparam int K_ILL = 0, K_ADD = 1, K_SUB = 2, K_AND = 3, K_OR = 4,
                 K_XOR = 5, K_NOR = 6, K_SLT = 7;

  typedef struct packed {
    logic [5:0]    opc;
    logic [5:0]    funct;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          zero;
    logic          ovf;
    logic          illegal;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    in_opcode = '0;
  logic [5:0]    in_funct = '0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [OW-1:0] alu_op_o;
  logic [DW-1:0] alu_a_o;
  logic [DW-1:0] alu_b_o;
  logic [DW-1:0] alu_result_i;
  logic          alu_zero_i;
  logic          alu_ovf_i;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_result;
  logic          out_zero;
  logic          out_overflow;
  logic          out_illegal;
  logic [CW-1:0] cnt_ops;
  logic [CW-1:0] cnt_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .alu_ovf_i(alu_ovf_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_overflow(out_overflow), .out_illegal(out_illegal),
    .cnt_ops(cnt_ops), .cnt_ovf(cnt_ovf)
  );

  // External ALU stand-in; raises a spurious overflow on non-arithmetic ops
  always_comb begin
    alu_result_i = '0;
    alu_ovf_i    = alu_a_o[DW-1] ^ alu_b_o[DW-1];
    case (alu_op_o)
      4'b0000: alu_result_i = alu_a_o & alu_b_o;
      4'b0001: alu_result_i = alu_a_o | alu_b_o;
      4'b0010: begin
        alu_result_i = alu_a_o + alu_b_o;
        alu_ovf_i = (alu_a_o[DW-1] == alu_b_o[DW-1]) && (alu_result_i[DW-1] != alu_a_o[DW-1]);
      end
      4'b0100: alu_result_i = alu_a_o ^ alu_b_o;
      4'b0110: begin
        alu_result_i = alu_a_o - alu_b_o;
        alu_ovf_i = (alu_a_o[DW-1] != alu_b_o[DW-1]) && (alu_result_i[DW-1] != alu_a_o[DW-1]);
      end
      4'b0111: alu_result_i = DW'($signed(alu_a_o) < $signed(alu_b_o));
      4'b1100: alu_result_i = ~(alu_a_o | alu_b_o);
      default: alu_result_i = '0;
    endcase
    alu_zero_i = (alu_result_i == '0);
  end

  // Reference: instruction semantics in plain signed arithmetic
  function automatic exp_t ref_model(input req_t r);
    exp_t   e;
    int     kind;
    longint sa, sb, w;
    sa = longint'($signed(r.a));
    sb = longint'($signed(r.b));
    kind = K_ILL;
    if (r.opc == 6'h00) begin
      case (r.funct)
        6'h20: kind = K_ADD;
        6'h22: kind = K_SUB;
        6'h24: kind = K_AND;
        6'h25: kind = K_OR;
        6'h26: kind = K_XOR;
        6'h27: kind = K_NOR;
        6'h2A: kind = K_SLT;
        default: kind = K_ILL;
      endcase
    end else begin
      case (r.opc)
        6'h08: kind = K_ADD;
        6'h0C: kind = K_AND;
        6'h0D: kind = K_OR;
        6'h0E: kind = K_XOR;
        6'h0A: kind = K_SLT;
        6'h04: kind = K_SUB;
        default: kind = K_ILL;
      endcase
    end
    e.illegal = (kind == K_ILL);
    e.ovf = 1'b0;
    e.result = '0;
    case (kind)
      K_ADD: begin w = sa + sb; e.result = DW'(w); e.ovf = (w > MAX32) || (w < MIN32); end
      K_SUB: begin w = sa - sb; e.result = DW'(w); e.ovf = (w > MAX32) || (w < MIN32); end
      K_AND: e.result = r.a & r.b;
      K_OR:  e.result = r.a | r.b;
      K_XOR: e.result = r.a ^ r.b;
      K_NOR: e.result = ~(r.a | r.b);
      K_SLT: e.result = (sa < sb) ? DW'(1) : DW'(0);
      default: e.result = '0;
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0000_0000;
      default: return DW'($urandom);
    endcase
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   k;
    k = $urandom_range(0, 9);
    case (k)
      4: r.opc = 6'h08;
      5: r.opc = 6'h0C;
      6: r.opc = 6'h0D;
      7: r.opc = 6'h0E;
      8: r.opc = ($urandom_range(0, 1) == 0) ? 6'h0A : 6'h04;
      9: r.opc = 6'($urandom);
      default: r.opc = 6'h00;
    endcase
    case ($urandom_range(0, 7))
      0: r.funct = 6'h20;
      1: r.funct = 6'h22;
      2: r.funct = 6'h24;
      3: r.funct = 6'h25;
      4: r.funct = 6'h26;
      5: r.funct = 6'h27;
      6: r.funct = 6'h2A;
      default: r.funct = 6'($urandom);
    endcase
    r.a = rand_operand();
    r.b = ($urandom_range(0, 5) == 0) ? r.a : rand_operand();
    return r;
  endfunction

  task automatic drive_req(input req_t r);
    in_opcode = r.opc;
    in_funct  = r.funct;
    in_a      = r.a;
    in_b      = r.b;
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Sends one request with out_ready high and captures the response
  task automatic do_one(input req_t r, output exp_t got, output logic [OW-1:0] op_seen,
                        output bit timeout);
    int n;
    timeout = 1'b0;
    @(negedge clk);
    drive_req(r);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) timeout = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_seen  = alu_op_o;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout = 1'b1;
    got = '{result: out_result, zero: out_zero, ovf: out_overflow, illegal: out_illegal};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    #3;
    checks++;
    if ({out_valid, out_result, out_zero, out_overflow, out_illegal} !== '0) begin
      failures++; $display("FAIL reset_outputs got valid=%0b result=%h want all 0", out_valid, out_result);
    end
    checks++;
    if ({alu_op_o, alu_a_o, alu_b_o} !== '0) begin
      failures++; $display("FAIL reset_alu_drive got op=%h a=%h b=%h want 0", alu_op_o, alu_a_o, alu_b_o);
    end
    checks++;
    if ({cnt_ops, cnt_ovf} !== '0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_cnt got ops=%0d ovf=%0d in_ready=%0b want 0 0 1", cnt_ops, cnt_ovf, in_ready);
    end
    apply_reset();
  endtask

  task automatic test_add_latency();
    apply_reset();
    @(negedge clk);
    in_opcode = 6'h00; in_funct = 6'h20; in_a = 32'd15; in_b = 32'd25;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready got %0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (alu_op_o !== 4'b0010 || alu_a_o !== 32'd15 || alu_b_o !== 32'd25 || out_valid !== 1'b0) begin
      failures++; $display("FAIL add_issue got op=%b a=%0d b=%0d ov=%0b want 0010 15 25 0",
                           alu_op_o, alu_a_o, alu_b_o, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd40 || out_zero !== 1'b0 ||
        out_overflow !== 1'b0 || out_illegal !== 1'b0) begin
      failures++; $display("FAIL add_result got v=%0b r=%0d z=%0b o=%0b i=%0b want 1 40 0 0 0",
                           out_valid, out_result, out_zero, out_overflow, out_illegal);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || cnt_ops !== CW'(1)) begin
      failures++; $display("FAIL add_drain got v=%0b cnt_ops=%0d want 0 1", out_valid, cnt_ops);
    end
  endtask

  task automatic test_sub_ovf();
    exp_t got; logic [OW-1:0] op; bit to; req_t r;
    apply_reset();
    r = '{opc: 6'h00, funct: 6'h22, a: 32'd50, b: 32'd50};
    do_one(r, got, op, to);
    checks++;
    if (to || got.result !== 32'd0 || got.zero !== 1'b1 || got.ovf !== 1'b0) begin
      failures++; $display("FAIL sub_zero got to=%0b r=%h z=%0b o=%0b want 0 0 1 0", to, got.result, got.zero, got.ovf);
    end
    r = '{opc: 6'h00, funct: 6'h22, a: 32'h8000_0000, b: 32'd1};
    do_one(r, got, op, to);
    checks++;
    if (to || got.result !== 32'h7FFF_FFFF || got.zero !== 1'b0 || got.ovf !== 1'b1) begin
      failures++; $display("FAIL sub_ovf got to=%0b r=%h z=%0b o=%0b want 0 7fffffff 0 1", to, got.result, got.zero, got.ovf);
    end
    checks++;
    if (cnt_ovf !== CW'(1) || cnt_ops !== CW'(2)) begin
      failures++; $display("FAIL sub_cnt got ovf=%0d ops=%0d want 1 2", cnt_ovf, cnt_ops);
    end
  endtask

  task automatic test_slti_illegal();
    exp_t got; logic [OW-1:0] op; bit to; req_t r;
    apply_reset();
    r = '{opc: 6'h0A, funct: 6'h00, a: 32'hFFFF_FFFB, b: 32'd10};
    do_one(r, got, op, to);
    checks++;
    if (to || op !== 4'b0111 || got.result !== 32'd1 || got.ovf !== 1'b0 || got.illegal !== 1'b0) begin
      failures++; $display("FAIL slti got to=%0b op=%b r=%h o=%0b i=%0b want 0 0111 1 0 0",
                           to, op, got.result, got.ovf, got.illegal);
    end
    r = '{opc: 6'h3F, funct: 6'h20, a: 32'h8000_1234, b: 32'd7};
    do_one(r, got, op, to);
    checks++;
    if (to || op !== 4'b1000 || got.result !== 32'd0 || got.zero !== 1'b1 ||
        got.ovf !== 1'b0 || got.illegal !== 1'b1) begin
      failures++; $display("FAIL illegal got to=%0b op=%b r=%h z=%0b o=%0b i=%0b want 0 1000 0 1 0 1",
                           to, op, got.result, got.zero, got.ovf, got.illegal);
    end
  endtask

  task automatic test_back_to_back();
    req_t v[4];
    logic [DW-1:0] want[4];
    int sent, delivered, c;
    v[0] = '{opc: 6'h00, funct: 6'h24, a: 32'hFFFF_0000, b: 32'h00FF_FF00};
    v[1] = '{opc: 6'h00, funct: 6'h25, a: 32'hFFFF_0000, b: 32'h0000_FFFF};
    v[2] = '{opc: 6'h00, funct: 6'h26, a: 32'hF0F0_F0F0, b: 32'h0F0F_0F0F};
    v[3] = '{opc: 6'h00, funct: 6'h27, a: 32'h0000_0000, b: 32'h0000_0000};
    want[0] = 32'h00FF_0000; want[1] = 32'hFFFF_FFFF;
    want[2] = 32'hFFFF_FFFF; want[3] = 32'hFFFF_FFFF;
    apply_reset();
    sent = 0; delivered = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (sent < 4);
      if (sent < 4) drive_req(v[sent]);
      out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== (sent < 2)) begin
        failures++; $display("FAIL b2b_in_ready cyc=%0d got %0b want %0b", k, in_ready, (sent < 2));
      end
      if (out_valid) begin
        checks++;
        if (out_result !== want[0]) begin
          failures++; $display("FAIL b2b_hold cyc=%0d got %h want %h", k, out_result, want[0]);
        end
      end
      if (in_valid && in_ready) sent++;
    end
    checks++;
    if (sent !== 2) begin failures++; $display("FAIL b2b_accepts got %0d want 2", sent); end
    c = 0;
    while (delivered < 4 && c < 20) begin
      @(negedge clk);
      in_valid = (sent < 4);
      if (sent < 4) drive_req(v[sent]);
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_result !== want[delivered]) begin
          failures++; $display("FAIL b2b_order idx=%0d got %h want %h", delivered, out_result, want[delivered]);
        end
        delivered++;
      end
      if (in_valid && in_ready) sent++;
      c++;
    end
    checks++;
    if (delivered !== 4) begin failures++; $display("FAIL b2b_count got %0d want 4", delivered); end
  endtask

  task automatic test_saturation();
    int sent, delivered, m, c;
    req_t r;
    apply_reset();
    sent = 0; delivered = 0; m = 0; c = 0;
    while (delivered < 17 && c < 60) begin
      @(negedge clk);
      r = '{opc: 6'h00, funct: 6'h20, a: DW'($urandom_range(0, 1000)), b: DW'($urandom_range(0, 1000))};
      in_valid = (sent < 17);
      drive_req(r);
      out_ready = 1'b1;
      #1;
      checks++;
      if (cnt_ops !== CW'(m)) begin
        failures++; $display("FAIL sat_step got %0d want %0d", cnt_ops, m);
      end
      if (out_valid && out_ready) begin delivered++; if (m < SAT) m++; end
      if (in_valid && in_ready) sent++;
      c++;
    end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if (delivered !== 17 || cnt_ops !== CW'(SAT)) begin
      failures++; $display("FAIL sat_final got delivered=%0d cnt_ops=%0d want 17 %0d", delivered, cnt_ops, SAT);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    req_t cur;
    bit pending, held;
    logic [DW+2:0] held_val;
    int m_ops, m_ovf;
    apply_reset();
    pending = 0; held = 0; m_ops = 0; m_ovf = 0; held_val = '0; cur = '0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      @(negedge clk);
      if (!pending && cyc < 300 && $urandom_range(0, 9) < 7) begin cur = rand_req(); pending = 1; end
      in_valid = pending;
      drive_req(cur);
      out_ready = (cyc >= 300) || ($urandom_range(0, 9) < 6);
      #1;
      checks++;
      if (cnt_ops !== CW'(m_ops) || cnt_ovf !== CW'(m_ovf)) begin
        failures++; $display("FAIL rnd_cnt cyc=%0d got ops=%0d ovf=%0d want %0d %0d", cyc, cnt_ops, cnt_ovf, m_ops, m_ovf);
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || {out_result, out_zero, out_overflow, out_illegal} !== held_val) begin
          failures++; $display("FAIL rnd_stable cyc=%0d got v=%0b r=%h", cyc, out_valid, out_result);
        end
      end
      held = out_valid && !out_ready;
      held_val = {out_result, out_zero, out_overflow, out_illegal};
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rnd_spurious cyc=%0d got r=%h want no response", cyc, out_result);
        end else begin
          e = q.pop_front();
          if ({out_result, out_zero, out_overflow, out_illegal} !== {e.result, e.zero, e.ovf, e.illegal}) begin
            failures++; $display("FAIL rnd_data cyc=%0d got r=%h z=%0b o=%0b i=%0b want r=%h z=%0b o=%0b i=%0b",
                                 cyc, out_result, out_zero, out_overflow, out_illegal,
                                 e.result, e.zero, e.ovf, e.illegal);
          end
          if (m_ops < SAT) m_ops++;
          if (e.ovf && m_ovf < SAT) m_ovf++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_model(cur));
        pending = 0;
        checks++;
        if (q.size() > 2) begin failures++; $display("FAIL rnd_inflight got %0d want <=2", q.size()); end
      end
    end
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL rnd_lost got %0d pending want 0", q.size()); end
  endtask

  task automatic test_reset_inflight();
    exp_t got; logic [OW-1:0] op; bit to; int seen;
    apply_reset();
    do_one('{opc: 6'h00, funct: 6'h22, a: 32'h8000_0000, b: 32'd1}, got, op, to);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    drive_req('{opc: 6'h08, funct: 6'h00, a: 32'd1, b: 32'd2});
    @(negedge clk);
    drive_req('{opc: 6'h08, funct: 6'h00, a: 32'd3, b: 32'd4});
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || cnt_ops !== CW'(1)) begin
      failures++; $display("FAIL rst_pre got v=%0b rdy=%0b ops=%0d want 1 0 1", out_valid, in_ready, cnt_ops);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || cnt_ops !== '0 || cnt_ovf !== '0 || alu_a_o !== '0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_async got v=%0b ops=%0d ovf=%0d a=%h rdy=%0b want 0 0 0 0 1",
                           out_valid, cnt_ops, cnt_ovf, alu_a_o, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0 || cnt_ops !== '0) begin
      failures++; $display("FAIL rst_discard got delivered=%0d cnt_ops=%0d want 0 0", seen, cnt_ops);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add_latency();
    test_sub_ovf();
    test_slti_illegal();
    test_back_to_back();
    test_saturation();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Pipelined initiator for the 32-bit ALU (4-bit alu_op encoding).
- Accepts instruction opcode/funct plus two operands over a valid/ready handshake and decodes them to alu_op.
- Drives the ALU from registered operands, then captures result and flags into an output register with its own valid/ready handshake.
- Maintains saturating statistics counters. Sits between register-read and writeback in the datapath.

Parameters:
DATA_WIDTH, 32, operand/result width
ALU_OP_WIDTH, 4, ALU control width
CNT_WIDTH, 16, statistics counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&&in_ready
in_opcode  in  6  instruction opcode
in_funct  in  6  funct field (used when opcode=0)
in_a  in  DATA_WIDTH  operand A
in_b  in  DATA_WIDTH  operand B
alu_op_o  out  ALU_OP_WIDTH  to ALU alu_op
alu_a_o  out  DATA_WIDTH  to ALU operand_a
alu_b_o  out  DATA_WIDTH  to ALU operand_b
alu_result_i  in  DATA_WIDTH  from ALU alu_result (combinational)
alu_zero_i  in  1  from ALU zero_flag
alu_ovf_i  in  1  from ALU overflow_flag
out_valid  out  1  response valid
out_ready  in  1  consumer ready
out_result  out  DATA_WIDTH  captured result
out_zero  out  1  captured zero flag
out_overflow  out  1  qualified overflow
out_illegal  out  1  unsupported opcode/funct
cnt_ops  out  CNT_WIDTH  responses delivered, saturating
cnt_ovf  out  CNT_WIDTH  delivered responses with out_overflow=1, saturating

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). All valids, registered ALU drives, outputs and counters clear to 0.
- Decode (R-type, opcode 0x00): funct 0x24→0000 AND, 0x25→0001 OR, 0x20→0010 ADD, 0x26→0100 XOR, 0x22→0110 SUB, 0x2A→0111 SLT, 0x27→1100 NOR.
- Decode (I-type): 0x08 ADDI→0010, 0x0C ANDI→0000, 0x0D ORI→0001, 0x0E XORI→0100, 0x0A SLTI→0111, 0x04 BEQ→0110.
- Any other opcode/funct: alu_op=1000 (ALU returns 0), illegal=1. The request still flows through the pipeline. No drop.
- Stage 1 (issue regs): on accept, the decoded alu_op, in_a and in_b are registered to alu_op_o/alu_a_o/alu_b_o, and s1_valid is set. These registers hold steady while stalled.
- Stage 2 (output regs): when s1_valid and advance, capture alu_result_i and alu_zero_i.
- out_overflow = alu_ovf_i && (op is ADD or SUB). It is masked to 0 for every other op.
- out_illegal carries the stage-1 illegal bit.
- Handshake: advance = !out_valid || out_ready; in_ready = !s1_valid || advance. in_ready has no combinational path from in_valid.
- Latency: a request accepted at edge N appears as out_valid=1 after edge N+1. Throughput is 1 per cycle with out_ready held high.
- Backpressure: with out_ready=0 and out_valid=1, both stages hold. At most 2 requests are in flight. All outputs stay stable until accepted.
- out_valid clears on out_ready unless a new stage-1 entry advances in the same cycle. Simultaneous drain and refill keeps out_valid=1 with new data.
- Counters increment on out_valid&&out_ready and hold at all-ones (no wrap).
- Reset mid-operation: in-flight requests are discarded and nothing is delivered.

Decomposition:
- Package alu_pkg: ALU_OP_* localparams (AND, OR, ADD, XOR, SUB, SLT, NOR, NULL=1000), OPC_* and FUNCT_* constants.
- Sub-module alu_op_decode: purely combinational, takes opcode and funct, returns alu_op and illegal.
- The ALU itself is external and wired to the alu_*_o / alu_*_i ports.

Test Plan:
- R-type ADD, a=15, b=25, out_ready=1 → out_result=40, zero=0, overflow=0, out_valid one cycle after accept.
- SUB, a=50, b=50 → result 0, zero=1. Then SUB, a=0x80000000, b=1 → result 0x7FFFFFFF, overflow=1, cnt_ovf=1.
- SLTI, a=-5, b=10 → result 1. Opcode 0x3F → alu_op_o=1000, result 0, illegal=1.
- Back-to-back AND/OR/XOR/NOR stream with out_ready=0 for 5 cycles → in_ready drops after 2 accepts, outputs stable, in-order delivery (0x00FF0000, 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFFFF for the standard vectors) with no loss.
- Preload cnt_ops near saturation (CNT_WIDTH=4, 17 transfers) → cnt_ops stays at 15.
- Assert rst_n low with 2 requests in flight → out_valid=0 immediately (asynchronous), counters 0, nothing delivered after release.
